// File: rtl/battleship_game_ctrl.sv
// rtl/battleship_game_ctrl.sv - battleship match sequencer: placement, alternating shots, win/lose
module battleship_game_ctrl #(
    parameter int          NUM_BOATS    = 3,
    parameter logic [31:0] TURN_TIMEOUT = 32'd250_000_000,
    parameter logic [31:0] PC_DELAY     = 32'd25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_confirm,
    input  logic [24:0] pc_layout,
    output logic [49:0] array_player,
    output logic [49:0] array_pc,
    output logic [4:0]  select_row,
    output logic [4:0]  select_col,
    output logic [4:0]  boat_row,
    output logic [4:0]  boat_col,
    output logic [2:0]  amount_boats,
    output logic        win,
    output logic        lose,
    output logic        player_turn
);

    typedef enum logic [3:0] {
        S_PLACE, S_PLAYER, S_CHECK, S_PC_WAIT, S_PC_PICK, S_PC_SCAN, S_PC_FIRE, S_WIN, S_LOSE
    } state_t;

    localparam logic [4:0] PLAYER_TOTAL = 5'(NUM_BOATS * (NUM_BOATS + 1) / 2);

    state_t      r_state;
    logic [7:0]  r_lfsr;
    logic [49:0] r_array_player;
    logic [49:0] r_array_pc;
    logic [24:0] r_pc_layout;
    logic [4:0]  r_pc_total;
    logic [4:0]  r_player_hits;
    logic [4:0]  r_pc_hits;
    logic [4:0]  r_sel_row;
    logic [4:0]  r_sel_col;
    logic [4:0]  r_boat_row;
    logic [4:0]  r_boat_col;
    logic [2:0]  r_amount;
    logic [31:0] r_timer;
    logic [31:0] r_delay;
    logic [4:0]  r_cand;
    logic        r_check_pc;
    logic        r_win;
    logic        r_lose;
    logic        r_player_turn;

    logic [7:0]  w_lfsr_next;
    logic [4:0]  w_pc_pop;
    logic [4:0]  w_place_mask;
    logic [4:0]  w_row_boats;
    logic [49:0] w_place_bits;
    logic        w_overlap;
    logic [4:0]  w_col_max;
    logic [4:0]  w_sel_cell;
    logic [5:0]  w_sel_idx0;
    logic [5:0]  w_sel_idx1;
    logic        w_sel_shot;
    logic [4:0]  w_pick;
    logic [4:0]  w_cand_next;

    assign w_lfsr_next  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_place_mask = (5'b11111 >> (3'd5 - r_amount)) << r_boat_col;
    assign w_overlap    = |(w_row_boats & w_place_mask);
    assign w_col_max    = 5'd5 - {2'b00, r_amount};
    assign w_sel_cell   = r_sel_row * 5'd5 + r_sel_col;
    assign w_sel_idx0   = {w_sel_cell, 1'b0};
    assign w_sel_idx1   = {w_sel_cell, 1'b1};
    assign w_sel_shot   = r_array_pc[w_sel_idx0];
    assign w_pick       = (r_lfsr[4:0] >= 5'd25) ? (r_lfsr[4:0] - 5'd25) : r_lfsr[4:0];
    assign w_cand_next  = (r_cand == 5'd24) ? 5'd0 : (r_cand + 5'd1);

    // Number of PC boat cells, latched as the player's hit target
    always_comb begin
        w_pc_pop = '0;
        for (int i = 0; i < 25; i++) begin
            w_pc_pop = w_pc_pop + {4'b0000, pc_layout[i]};
        end
    end

    // Boat bits of the cursor row and the bits a placement would set there
    always_comb begin
        w_row_boats  = '0;
        w_place_bits = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (r_boat_row == 5'(r)) begin
                    w_row_boats[c]              = r_array_player[r*10 + c*2 + 1];
                    w_place_bits[r*10 + c*2 + 1] = w_place_mask[c];
                end
            end
        end
    end

    // Game FSM with all board state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_PLACE;
            r_lfsr         <= 8'hA5;
            r_array_player <= '0;
            r_array_pc     <= '0;
            r_pc_layout    <= '0;
            r_pc_total     <= '0;
            r_player_hits  <= '0;
            r_pc_hits      <= '0;
            r_sel_row      <= '0;
            r_sel_col      <= '0;
            r_boat_row     <= '0;
            r_boat_col     <= '0;
            r_amount       <= 3'(NUM_BOATS);
            r_timer        <= '0;
            r_delay        <= '0;
            r_cand         <= '0;
            r_check_pc     <= 1'b0;
            r_win          <= 1'b0;
            r_lose         <= 1'b0;
            r_player_turn  <= 1'b0;
        end else if (start) begin
            r_state        <= S_PLACE;
            r_lfsr         <= 8'hA5;
            r_array_player <= '0;
            r_array_pc     <= '0;
            r_pc_layout    <= '0;
            r_pc_total     <= '0;
            r_player_hits  <= '0;
            r_pc_hits      <= '0;
            r_sel_row      <= '0;
            r_sel_col      <= '0;
            r_boat_row     <= '0;
            r_boat_col     <= '0;
            r_amount       <= 3'(NUM_BOATS);
            r_timer        <= '0;
            r_delay        <= '0;
            r_cand         <= '0;
            r_check_pc     <= 1'b0;
            r_win          <= 1'b0;
            r_lose         <= 1'b0;
            r_player_turn  <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_next;
            case (r_state)
                S_PLACE: begin
                    if (btn_confirm) begin
                        if (!w_overlap) begin
                            r_array_player <= r_array_player | w_place_bits;
                            r_amount       <= r_amount - 3'd1;
                            if (r_amount == 3'd1) begin
                                r_state       <= S_PLAYER;
                                r_pc_layout   <= pc_layout;
                                r_pc_total    <= w_pc_pop;
                                r_sel_row     <= '0;
                                r_sel_col     <= '0;
                                r_timer       <= '0;
                                r_player_turn <= 1'b1;
                            end
                        end
                    end else if (btn_up) begin
                        r_boat_row <= (r_boat_row == 5'd0) ? 5'd4 : (r_boat_row - 5'd1);
                    end else if (btn_down) begin
                        r_boat_row <= (r_boat_row == 5'd4) ? 5'd0 : (r_boat_row + 5'd1);
                    end else if (btn_left) begin
                        if (r_boat_col != 5'd0) r_boat_col <= r_boat_col - 5'd1;
                    end else if (btn_right) begin
                        if (r_boat_col < w_col_max) r_boat_col <= r_boat_col + 5'd1;
                    end
                end
                S_PLAYER: begin
                    if (btn_confirm && !w_sel_shot) begin
                        r_array_pc[w_sel_idx0] <= 1'b1;
                        r_array_pc[w_sel_idx1] <= r_pc_layout[w_sel_cell];
                        if (r_pc_layout[w_sel_cell]) r_player_hits <= r_player_hits + 5'd1;
                        r_check_pc    <= 1'b0;
                        r_state       <= S_CHECK;
                        r_player_turn <= 1'b0;
                    end else if (r_timer == TURN_TIMEOUT - 32'd1) begin
                        r_delay       <= '0;
                        r_state       <= S_PC_WAIT;
                        r_player_turn <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                        // a confirm on an already-shot cell still consumes the cycle's action
                        if (!btn_confirm) begin
                            if (btn_up) begin
                                r_sel_row <= (r_sel_row == 5'd0) ? 5'd4 : (r_sel_row - 5'd1);
                            end else if (btn_down) begin
                                r_sel_row <= (r_sel_row == 5'd4) ? 5'd0 : (r_sel_row + 5'd1);
                            end else if (btn_left) begin
                                r_sel_col <= (r_sel_col == 5'd0) ? 5'd4 : (r_sel_col - 5'd1);
                            end else if (btn_right) begin
                                r_sel_col <= (r_sel_col == 5'd4) ? 5'd0 : (r_sel_col + 5'd1);
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (!r_check_pc) begin
                        if (r_player_hits == r_pc_total) begin
                            r_state <= S_WIN;
                            r_win   <= 1'b1;
                        end else begin
                            r_delay <= '0;
                            r_state <= S_PC_WAIT;
                        end
                    end else begin
                        if (r_pc_hits == PLAYER_TOTAL) begin
                            r_state <= S_LOSE;
                            r_lose  <= 1'b1;
                        end else begin
                            r_timer       <= '0;
                            r_state       <= S_PLAYER;
                            r_player_turn <= 1'b1;
                        end
                    end
                end
                S_PC_WAIT: begin
                    if (r_delay == PC_DELAY - 32'd1) r_state <= S_PC_PICK;
                    else                             r_delay <= r_delay + 32'd1;
                end
                S_PC_PICK: begin
                    r_cand  <= w_pick;
                    r_state <= S_PC_SCAN;
                end
                S_PC_SCAN: begin
                    if (r_array_player[{r_cand, 1'b0}]) r_cand  <= w_cand_next;
                    else                                r_state <= S_PC_FIRE;
                end
                S_PC_FIRE: begin
                    r_array_player[{r_cand, 1'b0}] <= 1'b1;
                    if (r_array_player[{r_cand, 1'b1}]) r_pc_hits <= r_pc_hits + 5'd1;
                    r_check_pc <= 1'b1;
                    r_state    <= S_CHECK;
                end
                S_WIN, S_LOSE: begin
                end
                default: r_state <= S_PLACE;
            endcase
        end
    end

    assign array_player = r_array_player;
    assign array_pc     = r_array_pc;
    assign select_row   = r_sel_row;
    assign select_col   = r_sel_col;
    assign boat_row     = r_boat_row;
    assign boat_col     = r_boat_col;
    assign amount_boats = r_amount;
    assign win          = r_win;
    assign lose         = r_lose;
    assign player_turn  = r_player_turn;

endmodule
